lbr_drain_engine: RTL and testbench
===================================

# lbr_drain_engine

Read-side companion to the last-branch-record (LBR) unit. On a start pulse it snapshots the LBR top-of-stack pointer, then walks the ring newest-to-oldest. For each entry it reads the branch-source (FROM) word and the branch-target (TO) word through the LBR read port, and emits each pair on a valid/ready stream. The stream feeds the debug/trace export path; the engine sits beside the LBR unit and owns its read-request lines while busy.

## Interface
- DATA_WIDTH, 64, width of LBR words and stream payload
- LBR_SIZE, 16, number of LBR entries; power of two, ≥2
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse; begins a drain when idle
- start_count  in  clog2(LBR_SIZE)+1  number of entries to drain
- lbr_rd_req  out  1  LBR read request (memory-mapped read select)
- lbr_rd_addr  out  clog2(LBR_SIZE)+2  LBR word address
- lbr_rd_data  in  DATA_WIDTH  LBR read data, combinational from lbr_rd_addr
- lbr_freeze  out  1  recording-suppress request to LBR stall input
- out_valid  out  1  stream entry valid
- out_ready  in  1  consumer accepts entry
- out_from  out  DATA_WIDTH  branch source PC
- out_to  out  DATA_WIDTH  branch target PC
- out_age  out  clog2(LBR_SIZE)  0 = most recent branch
- out_last  out  1  final entry of this drain
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse after final handshake

## Operation
- LBR address map, with W = clog2(LBR_SIZE)+2:
  - FROM[i] = {2'b00, i}
  - TO[i] = {2'b01, i}
  - TOS = 1<<(W-1); its low clog2(LBR_SIZE) bits are the index of the newest entry.
- FSM states and transitions:
  - IDLE -> RD_TOS on start.
  - RD_TOS -> RD_FROM.
  - RD_FROM -> RD_TO.
  - RD_TO -> EMIT.
  - EMIT -> RD_FROM on handshake when remaining > 0; EMIT -> DONE on handshake when remaining = 0.
  - DONE -> IDLE.
- RD_TOS:
  - Drive addr = TOS.
  - Latch idx = rd_data[clog2(LBR_SIZE)-1:0].
  - Latch remaining = clamped count − 1.
  - age = 0.
- RD_FROM: drive FROM[idx]; latch into out_from register.
- RD_TO: drive TO[idx]; latch into out_to register.
- EMIT:
  - out_valid = 1; payload held stable until out_ready.
  - On handshake: idx = (idx − 1) mod LBR_SIZE, wrapping from 0 to LBR_SIZE−1; age += 1; remaining −= 1.
- lbr_rd_req = 1 in RD_TOS, RD_FROM and RD_TO; 0 otherwise. lbr_rd_addr = 0 when lbr_rd_req is 0.
- Count clamp: start_count = 0 or start_count > LBR_SIZE is treated as LBR_SIZE.
- out_last = 1 during EMIT when remaining = 0.
- busy = 1 in every state except IDLE. done = 1 only in DONE.
- start while busy is ignored; no queuing.
- out_ready while out_valid = 0 has no effect.
- Reset:
  - Asynchronous assertion forces IDLE immediately, mid-drain included.
  - All outputs reset to 0: busy, done, out_valid, out_last, out_from, out_to, out_age, lbr_rd_req, lbr_rd_addr, lbr_freeze.
  - No done pulse on an aborted drain.

## Timing
- start sampled at edge 0 → RD_TOS in cycle 1.
- FROM read in cycle 2, TO read in cycle 3, first out_valid in cycle 4.
- Per entry: 3 cycles minimum (RD_FROM, RD_TO, EMIT). Each cycle of out_ready low adds one EMIT cycle.
- With out_ready held high, N entries take 1 + 3N cycles from RD_TOS to the last handshake. done is asserted the following cycle, busy falls with done, and the next start is accepted the cycle after done.
- lbr_rd_data is sampled at the end of the cycle the address is driven (zero-wait combinational read).
- All outputs are registered or decoded from state; no combinational path from out_ready to out_valid.

## Configuration
- LBR_DRAIN_FREEZE_EN:
  - Defined: lbr_freeze = busy. The LBR unit ORs this into its stall, so no new branch is recorded during a drain and the snapshot stays coherent.
  - Undefined: lbr_freeze is tied 0. Branches may record during a drain; TOS is still snapshotted once, but entries overwritten mid-drain are emitted with their new contents.

## Test plan
- Pre-load LBR_SIZE=16 with TOS=5, FROM[i]=0x1000+i, TO[i]=0x2000+i. Drain with start_count=3 and out_ready=1 → three entries:
  - (0x1005, 0x2005, age 0)
  - (0x1004, 0x2004, age 1)
  - (0x1003, 0x2003, age 2, last=1)
  - done pulses 11 cycles after start.
- Wrap-around: TOS=1, start_count=4 → indices 1, 0, 15, 14 emitted in that order.
- Count clamp: start_count=0 and start_count=20 each emit exactly 16 entries, the last at age 15 with out_last=1.
- Backpressure: out_ready low 5 cycles during the second EMIT → payload held stable, valid held high, total latency increases by exactly 5 cycles. A start pulse during busy is ignored.
- Reset asserted in RD_TO of the second entry → all outputs 0 immediately, no done pulse. A fresh start after release drains normally from entry 0.
- With LBR_DRAIN_FREEZE_EN defined, lbr_freeze equals busy for the whole drain. With it undefined, lbr_freeze stays 0.

Source files
------------

// File: rtl/lbr_drain_engine.sv
`default_nettype none
// ============================================================================
// Module   : lbr_drain_engine
// Brief    : Walks the last-branch-record ring newest-to-oldest. It reads the
//            FROM/TO word pair for each entry through the LBR read port and
//            emits each pair on a valid/ready stream.
// Options  : LBR_DRAIN_FREEZE_EN - when defined, lbr_freeze follows busy so
//            the LBR stops recording for the whole drain. When undefined,
//            lbr_freeze is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module lbr_drain_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int LBR_SIZE   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(LBR_SIZE):0]   start_count,
    output logic                        lbr_rd_req,
    output logic [$clog2(LBR_SIZE)+1:0] lbr_rd_addr,
    input  logic [DATA_WIDTH-1:0]       lbr_rd_data,
    output logic                        lbr_freeze,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_from,
    output logic [DATA_WIDTH-1:0]       out_to,
    output logic [$clog2(LBR_SIZE)-1:0] out_age,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int c_iw = $clog2(LBR_SIZE);
    localparam int c_cw = c_iw + 1;
    localparam int c_aw = c_iw + 2;

    // The TOS word lives at 1 << (c_aw-1). The FROM bank is 2'b00 and the TO bank is 2'b01.
    localparam logic [c_aw-1:0] c_tos_addr = {2'b10, {c_iw{1'b0}}};
    localparam logic [c_cw-1:0] c_size     = c_cw'(LBR_SIZE);
    localparam logic [c_iw-1:0] c_max_rem  = c_iw'(LBR_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_TOS  = 3'd1,
        S_RD_FROM = 3'd2,
        S_RD_TO   = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          r_state;
    logic [c_iw-1:0] r_idx;
    logic [c_iw-1:0] r_remaining;

    logic            w_clamp;
    logic [c_iw-1:0] w_rem_init;
    logic [c_iw-1:0] w_idx_next;
    logic [c_iw-1:0] w_tos_idx;

    // A zero or oversized count drains the whole ring. The remaining counter starts at count-1.
    assign w_clamp    = (start_count == '0) || (start_count > c_size);
    assign w_rem_init = w_clamp ? c_max_rem : c_iw'(start_count - 1'b1);
    // Step to the next-older entry. The wrap from 0 to LBR_SIZE-1 comes from the power-of-two width.
    assign w_idx_next = r_idx - 1'b1;
    assign w_tos_idx  = lbr_rd_data[c_iw-1:0];

    // This is the drain sequencer. Each output is registered, so it changes together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_remaining <= '0;
            lbr_rd_req  <= 1'b0;
            lbr_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_from    <= '0;
            out_to      <= '0;
            out_age     <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RD_TOS;
                        r_remaining <= w_rem_init;
                        lbr_rd_req  <= 1'b1;
                        lbr_rd_addr <= c_tos_addr;
                        busy        <= 1'b1;
                    end
                end
                S_RD_TOS: begin
                    // Snapshot the newest index once. The walk then ignores any later TOS movement.
                    r_state     <= S_RD_FROM;
                    r_idx       <= w_tos_idx;
                    out_age     <= '0;
                    lbr_rd_addr <= {2'b00, w_tos_idx};
                end
                S_RD_FROM: begin
                    r_state     <= S_RD_TO;
                    out_from    <= lbr_rd_data;
                    lbr_rd_addr <= {2'b01, r_idx};
                end
                S_RD_TO: begin
                    r_state     <= S_EMIT;
                    out_to      <= lbr_rd_data;
                    lbr_rd_req  <= 1'b0;
                    lbr_rd_addr <= '0;
                    out_valid   <= 1'b1;
                    out_last    <= (r_remaining == '0);
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (r_remaining == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state     <= S_RD_FROM;
                            r_idx       <= w_idx_next;
                            r_remaining <= r_remaining - 1'b1;
                            out_age     <= out_age + 1'b1;
                            lbr_rd_req  <= 1'b1;
                            lbr_rd_addr <= {2'b00, w_idx_next};
                        end
                    end
                end
                S_DONE: begin
                    // busy drops together with done. A new start is accepted from the next cycle.
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    lbr_rd_req  <= 1'b0;
                    lbr_rd_addr <= '0;
                    out_valid   <= 1'b0;
                    out_last    <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

`ifdef LBR_DRAIN_FREEZE_EN
    // Hold off LBR recording for the whole drain so that the snapshot stays coherent.
    assign lbr_freeze = busy;
`else
    assign lbr_freeze = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lbr_drain_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbr_drain_engine
// Brief    : Self-checking bench for lbr_drain_engine. A behavioural LBR
//            memory model predicts each emitted entry, its age and last flag,
//            and the cycle of the done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbr_drain_engine;

    localparam int DW = 64;
    localparam int LS = 16;

`ifdef LBR_DRAIN_FREEZE_EN
    localparam bit c_frz = 1'b1;
`else
    localparam bit c_frz = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    start_count = '0;
    logic          lbr_rd_req;
    logic [5:0]    lbr_rd_addr;
    logic [DW-1:0] lbr_rd_data;
    logic          lbr_freeze;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_from;
    logic [DW-1:0] out_to;
    logic [3:0]    out_age;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference LBR contents
    logic [63:0] mem_from [LS];
    logic [63:0] mem_to   [LS];
    logic [63:0] tos_word;
    int          tos_val;

    lbr_drain_engine #(.DATA_WIDTH(DW), .LBR_SIZE(LS)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_count (start_count),
        .lbr_rd_req  (lbr_rd_req),
        .lbr_rd_addr (lbr_rd_addr),
        .lbr_rd_data (lbr_rd_data),
        .lbr_freeze  (lbr_freeze),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_from    (out_from),
        .out_to      (out_to),
        .out_age     (out_age),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Zero-wait LBR read port
    always_comb begin
        lbr_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
        case (lbr_rd_addr[5:4])
            2'b00:   lbr_rd_data = mem_from[lbr_rd_addr[3:0]];
            2'b01:   lbr_rd_data = mem_to[lbr_rd_addr[3:0]];
            2'b10:   lbr_rd_data = tos_word;
            default: lbr_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_tos(input int t);
        tos_val  = t;
        tos_word = {$urandom(), $urandom()};
        tos_word[3:0] = 4'(t);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < LS; i++) begin
            mem_from[i] = 64'h1000 + 64'(i);
            mem_to[i]   = 64'h2000 + 64'(i);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < LS; i++) begin
            mem_from[i] = {$urandom(), $urandom()};
            mem_to[i]   = {$urandom(), $urandom()};
        end
    endtask

    // Runs one drain. The task is entered and left 1 time unit after a rising edge.
    task automatic run_drain(input int cnt, input int stall_entry, input int stall_len,
                             input bit rand_ready, input bit poke, output int done_cyc);
        int n, got, cyc, stalls, stalled, idx;
        bit pending, seen;
        logic [63:0] h_from, h_to;
        logic [3:0]  h_age;
        n = (cnt == 0 || cnt > LS) ? LS : cnt;
        got = 0; stalls = 0; stalled = 0; pending = 0; seen = 0; done_cyc = -1;
        h_from = '0; h_to = '0; h_age = '0;
        out_ready   = 1'b1;
        start       = 1'b1;
        start_count = 5'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!seen && cyc < 1000) begin
            start = 1'b0;
            check("busy", busy, 1);
            check("freeze", lbr_freeze, c_frz);
            if (!lbr_rd_req) check("addr_idle", lbr_rd_addr, 0);
            if (cyc == 4) check("first_valid", out_valid, 1);
            if (pending) begin
                check("valid_hold", out_valid, 1);
                check("hold_from", out_from, h_from);
                check("hold_to", out_to, h_to);
                check("hold_age", out_age, h_age);
            end
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                check("done_cyc", cyc, 3 * n + 2 + stalls);
            end else begin
                if (out_valid && got == stall_entry && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else if (rand_ready) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    out_ready = 1'b1;
                end
                if (out_valid && out_ready) begin
                    if (got < n) begin
                        idx = ((tos_val - got) % LS + LS) % LS;
                        check("from", out_from, mem_from[idx]);
                        check("to", out_to, mem_to[idx]);
                        check("age", out_age, got);
                        check("last", out_last, (got == n - 1));
                    end else begin
                        check("extra_entry", got, n - 1);
                    end
                    got++;
                    pending = 0;
                end else if (out_valid) begin
                    stalls++;
                    if (!pending) begin
                        h_from = out_from; h_to = out_to; h_age = out_age;
                        pending = 1;
                    end
                end
                if (poke && cyc == 5) begin
                    start = 1'b1;
                    start_count = 5'd1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        check("entries", got, n);
        check("done_pulse", done, 0);
        check("busy_off", busy, 0);
        check("freeze_idle", lbr_freeze, 0);
    endtask

    initial begin
        int lat_base, lat_bp, lat, dcount;
        fill_pattern();
        set_tos(5);

        // Values while in reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {busy, done, out_valid, out_last, lbr_rd_req, lbr_freeze}, 0);
        check("rst_age", out_age, 0);
        check("rst_addr", lbr_rd_addr, 0);
        check("rst_from", out_from, 0);
        check("rst_to", out_to, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed drain: TOS=5, count 3
        run_drain(3, -1, 0, 1'b0, 1'b0, lat_base);
        check("done_at_11", lat_base, 11);

        // Wrap-around from TOS=1
        set_tos(1);
        run_drain(4, -1, 0, 1'b0, 1'b0, lat);

        // Count clamp
        set_tos(7);
        run_drain(0, -1, 0, 1'b0, 1'b0, lat);
        set_tos(12);
        run_drain(20, -1, 0, 1'b0, 1'b0, lat);

        // Backpressure on the second entry, with a stray start while busy
        set_tos(5);
        run_drain(3, 1, 5, 1'b0, 1'b1, lat_bp);
        check("bp_latency", lat_bp, lat_base + 5);

        // Reset during RD_TO of the second entry
        set_tos(9);
        out_ready   = 1'b1;
        start       = 1'b1;
        start_count = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 6; c++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_addr", lbr_rd_addr, 6'h18);
        rst_n = 1'b0;
        #1;
        check("arst_ctl", {busy, done, out_valid, out_last, lbr_rd_req, lbr_freeze}, 0);
        check("arst_age", out_age, 0);
        check("arst_addr", lbr_rd_addr, 0);
        check("arst_from", out_from, 0);
        check("arst_to", out_to, 0);
        dcount = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done) dcount++;
        check("no_done", dcount, 0);
        set_tos(3);
        run_drain(3, -1, 0, 1'b0, 1'b0, lat);

        // Randomized drains
        for (int r = 0; r < 25; r++) begin
            fill_random();
            set_tos($urandom_range(0, 15));
            run_drain($urandom_range(0, 31),
                      (r % 3 == 0) ? int'($urandom_range(0, 3)) : -1,
                      $urandom_range(1, 4), 1'b1, (r % 4 == 1), lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
